// File: rtl/scalar_instr_queue.sv
// Instruction queue feeding the scalar core's decode stage: a DEPTH-entry FIFO followed by a
// registered output stage that issues one instruction per cycle, or a NOP bubble if none is ready.
module scalar_instr_queue #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [31:0]                in_instr,
    output logic                       in_ready,
    input  logic                       stall,
    input  logic                       flush,
    output logic [31:0]                instr_out,
    output logic                       instr_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [31:0]     mem [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            push, pop;

    assign full     = (count_q == CntW'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full && !flush;

    assign push = in_valid && in_ready;
    assign pop  = !stall && !flush && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            instr_d  = NOP_INSTR;
            valid_d  = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            // No bypass: a word pushed into an empty queue issues one edge later.
            if (!stall) begin
                if (!empty) begin
                    instr_d  = mem[rd_ptr_q];
                    valid_d  = 1'b1;
                    rd_ptr_d = rd_ptr_q + PtrW'(1);
                end else begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
        end
    end

    // Storage needs no reset; occupancy is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_instr;
        end
    end

    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign count       = count_q;

endmodule

// File: tb/tb_scalar_instr_queue.sv
// Directed bench for scalar_instr_queue: each task drives one scenario and checks hand-derived values.
module tb_scalar_instr_queue;

    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        stall;
    logic        flush;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [3:0]  count;
    logic        full;
    logic        empty;

    int checks = 0;
    int errors = 0;

    scalar_instr_queue #(
        .DEPTH    (DEPTH),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .stall      (stall),
        .flush      (flush),
        .instr_out  (instr_out),
        .instr_valid(instr_valid),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; stall = 1'b0; flush = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        checks++; if (instr_out !== NOP) begin errors++;
            $display("FAIL reset_instr_out got %h exp %h", instr_out, NOP); end
        checks++; if (instr_valid !== 1'b0) begin errors++;
            $display("FAIL reset_instr_valid got %b exp 0", instr_valid); end
        checks++; if (empty !== 1'b1) begin errors++;
            $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (count !== 4'd0) begin errors++;
            $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (full !== 1'b0) begin errors++;
            $display("FAIL reset_full got %b exp 0", full); end
    endtask

    task automatic test_fill_stall();
        stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_instr = 32'hA000_0001 + i;
            tick();
        end
        checks++; if (count !== 4'd8) begin errors++;
            $display("FAIL fill_count got %0d exp 8", count); end
        checks++; if (full !== 1'b1 || in_ready !== 1'b0) begin errors++;
            $display("FAIL fill_full_ready got full=%b ready=%b exp 1/0", full, in_ready); end
        checks++; if (instr_valid !== 1'b0) begin errors++;
            $display("FAIL fill_held_valid got %b exp 0", instr_valid); end
        in_instr = 32'h9999_9999;
        tick();
        checks++; if (count !== 4'd8) begin errors++;
            $display("FAIL fill_ninth_rejected count got %0d exp 8", count); end
        in_valid = 1'b0; stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (instr_out !== 32'hA000_0001 + i || instr_valid !== 1'b1 || count !== 4'(7 - i))
            begin
                errors++;
                $display("FAIL drain_%0d got %h/%b cnt %0d exp %h/1 cnt %0d", i, instr_out,
                         instr_valid, count, 32'hA000_0001 + i, 7 - i);
            end
        end
        tick();
        checks++; if (instr_out !== NOP || instr_valid !== 1'b0 || empty !== 1'b1) begin errors++;
            $display("FAIL drain_bubble got %h/%b empty %b exp %h/0 empty 1", instr_out,
                     instr_valid, empty, NOP); end
    endtask

    task automatic test_latency();
        in_valid = 1'b1; in_instr = 32'h1234_5678;
        tick();
        in_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0 || count !== 4'd1) begin errors++;
            $display("FAIL lat_no_bypass got valid %b cnt %0d exp 0 cnt 1", instr_valid, count); end
        tick();
        checks++; if (instr_out !== 32'h1234_5678 || instr_valid !== 1'b1) begin errors++;
            $display("FAIL lat_issue got %h/%b exp 12345678/1", instr_out, instr_valid); end
        tick();
        checks++; if (instr_out !== NOP || instr_valid !== 1'b0) begin errors++;
            $display("FAIL lat_bubble got %h/%b exp %h/0", instr_out, instr_valid, NOP); end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_instr = 32'hB000_0000 + i;
            tick();
            checks++; if (count !== 4'd1) begin errors++;
                $display("FAIL stream_count_%0d got %0d exp 1", i, count); end
            if (i > 0) begin
                checks++;
                if (instr_out !== 32'hB000_0000 + i - 1 || instr_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_out_%0d got %h/%b exp %h/1", i, instr_out, instr_valid,
                             32'hB000_0000 + i - 1);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (instr_out !== 32'hB000_0013 || instr_valid !== 1'b1) begin errors++;
            $display("FAIL stream_last got %h/%b exp b0000013/1", instr_out, instr_valid); end
        tick();
        checks++; if (instr_valid !== 1'b0 || empty !== 1'b1) begin errors++;
            $display("FAIL stream_end got valid %b empty %b exp 0/1", instr_valid, empty); end
    endtask

    task automatic test_stall_flush();
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_instr = 32'hC000_0000 + i;
            tick();
        end
        in_valid = 1'b0; stall = 1'b0;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (instr_out !== 32'hC000_0000 || instr_valid !== 1'b1 || count !== 4'd5) begin
                errors++;
                $display("FAIL stall_hold_%0d got %h/%b cnt %0d exp c0000000/1 cnt 5", i,
                         instr_out, instr_valid, count);
            end
        end
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'hDEAD_BEEF;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++;
            $display("FAIL flush_in_ready got %b exp 0", in_ready); end
        tick();
        checks++;
        if (count !== 4'd0 || instr_valid !== 1'b0 || instr_out !== NOP || empty !== 1'b1) begin
            errors++;
            $display("FAIL flush_state got cnt %0d %h/%b empty %b exp 0 %h/0 1", count,
                     instr_out, instr_valid, empty, NOP);
        end
        flush = 1'b0; in_valid = 1'b0; stall = 1'b0;
        tick();
        checks++; if (instr_valid !== 1'b0 || count !== 4'd0) begin errors++;
            $display("FAIL flush_word_dropped got valid %b cnt %0d exp 0/0", instr_valid, count); end
    endtask

    task automatic test_async_reset();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_instr = 32'hD000_0000 + i;
            tick();
        end
        in_valid = 1'b0; stall = 1'b0;
        tick();
        checks++; if (count !== 4'd4 || instr_out !== 32'hD000_0000) begin errors++;
            $display("FAIL arst_pre got cnt %0d %h exp 4 d0000000", count, instr_out); end
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (instr_out !== NOP || instr_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL arst_immediate got %h/%b cnt %0d empty %b exp %h/0 0 1", instr_out,
                     instr_valid, count, empty, NOP);
        end
        tick();
        rst_n = 1'b1; stall = 1'b0;
        tick();
        checks++; if (instr_valid !== 1'b0 || count !== 4'd0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL arst_after got valid %b cnt %0d ready %b exp 0 0 1", instr_valid,
                     count, in_ready); end
        in_valid = 1'b1; in_instr = 32'hE000_0001;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (instr_out !== 32'hE000_0001 || instr_valid !== 1'b1) begin errors++;
            $display("FAIL arst_fresh got %h/%b exp e0000001/1", instr_out, instr_valid); end
    endtask

    initial begin
        test_reset();
        test_fill_stall();
        test_latency();
        test_streaming();
        test_stall_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
